instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch.sv | 135 +++++++++++++
 tb/tb_instruction_fetch.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-memory fetch bus.
//   imem_req   : fetch stage -> memory, request is active this cycle
//   imem_addr  : fetch stage -> memory, fetch address (the current PC)
//   imem_ready : memory -> fetch stage, request accepted and data valid
//   imem_rdata : memory -> fetch stage, 32-bit instruction word
// Handshake: a transfer happens in exactly the cycle where imem_req and
// imem_ready are both 1. imem_rdata is sampled in that cycle. Nothing is
// outstanding after it. imem_addr is meaningful whenever imem_req is 1.
interface instruction_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage of the pipelined ARMv8 core. Owns the PC, fetches instructions
// over the imem bus and drives the IF/ID pipeline register.
// Ports:
//   clock, reset      : single clock, synchronous active-high reset
//   stall             : hazard unit hold of IF/ID and PC
//   branch_taken      : redirect fetch to branch_target and flush IF/ID
//   branch_target     : redirect address (used as given)
//   imem              : fetch bus (master side)
//   instruction       : IF/ID instruction word
//   PC_out            : IF/ID PC of that instruction
//   PC_plus4_out      : IF/ID PC_out + 4 (branch-link value)
//   valid             : IF/ID holds a real instruction (0 = bubble)
//   state_dbg         : FSM state, 0 = S_REQ, 1 = S_HOLD
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [63:0]                branch_target,
  instruction_fetch_if.master        imem,
  output logic [31:0]                instruction,
  output logic [63:0]                PC_out,
  output logic [63:0]                PC_plus4_out,
  output logic                       valid,
  output logic                       state_dbg
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] buf_word_q, buf_word_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_out_q, pc_out_d;
  logic [63:0] pc_p4_q, pc_p4_d;
  logic        valid_q, valid_d;

  logic        transfer;
  logic [63:0] pc_plus4;

  // Request is gated by reset so the bus is quiet while reset is held.
  assign imem.imem_req  = (state_q == S_REQ) && !reset;
  assign imem.imem_addr = pc_q;
  assign transfer       = imem.imem_req && imem.imem_ready;
  assign pc_plus4       = pc_q + 64'd4;  // wraps modulo 2^64

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_word_d = buf_word_q;
    buf_pc_d   = buf_pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_p4_d    = pc_p4_q;
    valid_d    = valid_q;

    if (branch_taken) begin
      // Redirect beats stall; any same-cycle transfer and the hold
      // buffer are discarded. PC_out/PC_plus4_out keep their values.
      pc_d    = branch_target;
      state_d = S_REQ;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (transfer) begin
            pc_d = pc_plus4;
            if (stall) begin
              // Word is accepted but IF/ID is frozen: park it.
              buf_word_d = imem.imem_rdata;
              buf_pc_d   = pc_q;
              state_d    = S_HOLD;
            end else begin
              instr_d  = imem.imem_rdata;
              pc_out_d = pc_q;
              pc_p4_d  = pc_plus4;
              valid_d  = 1'b1;
            end
          end else if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            // PC already advanced past the buffered word.
            instr_d  = buf_word_q;
            pc_out_d = buf_pc_q;
            pc_p4_d  = buf_pc_q + 64'd4;
            valid_d  = 1'b1;
            state_d  = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      buf_word_q <= '0;
      buf_pc_q   <= '0;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= '0;
      pc_p4_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_word_q <= buf_word_d;
      buf_pc_q   <= buf_pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_p4_q    <= pc_p4_d;
      valid_q    <= valid_d;
    end
  end

  assign instruction  = instr_q;
  assign PC_out       = pc_out_q;
  assign PC_plus4_out = pc_p4_q;
  assign valid        = valid_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] NOP     = 32'hD503201F;
  localparam logic [63:0] TOP_PC  = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          W       = 96;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, reset1;
  logic        stall, branch_taken;
  logic [63:0] branch_target;
  logic        rdy0, rdy1;
  logic        zero1 = 1'b0;
  logic [63:0] zero64 = 64'h0;

  logic [31:0] instruction0, instruction1;
  logic [63:0] pc_out0, pc_out1, p4_out0, p4_out1;
  logic        valid0, valid1, st0, st1;

  instruction_fetch_if bus0 ();
  instruction_fetch_if bus1 ();

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  // Memory model: word is a pure function of the address.
  assign bus0.imem_ready = rdy0;
  assign bus0.imem_rdata = word_of(bus0.imem_addr);
  assign bus1.imem_ready = rdy1;
  assign bus1.imem_rdata = word_of(bus1.imem_addr);

  instruction_fetch dut0 (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(bus0.master), .instruction(instruction0), .PC_out(pc_out0),
    .PC_plus4_out(p4_out0), .valid(valid0), .state_dbg(st0)
  );

  instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
    .clock(clock), .reset(reset1), .stall(zero1),
    .branch_taken(zero1), .branch_target(zero64),
    .imem(bus1.master), .instruction(instruction1), .PC_out(pc_out1),
    .PC_plus4_out(p4_out1), .valid(valid1), .state_dbg(st1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [63:0] tgt;
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_p4;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic s, input logic b, input logic [63:0] t,
                              input logic r, input logic eq, input logic [63:0] ea,
                              input logic ev, input logic [63:0] ep, input logic [63:0] e4);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.rdy = r;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_p4 = e4;
    return v;
  endfunction

  // Scoreboard: {pc, word} of each accepted fetch, popped when IF/ID shows it.
  logic [W-1:0] exp_q[$];

  initial begin
    logic [63:0]  exp_addr;
    logic [W-1:0] item;

    //            stall br   tgt        rdy  req addr      vld pc_out     pc+4
    vecs[0]  = mk(1'b0,1'b0,64'h0,     1'b1,1'b1,64'h4,   1'b1,64'h0,   64'h4);
    vecs[1]  = mk(1'b0,1'b0,64'h0,     1'b1,1'b1,64'h8,   1'b1,64'h4,   64'h8);
    vecs[2]  = mk(1'b0,1'b0,64'h0,     1'b0,1'b1,64'h8,   1'b0,64'h4,   64'h8);
    vecs[3]  = mk(1'b0,1'b0,64'h0,     1'b0,1'b1,64'h8,   1'b0,64'h4,   64'h8);
    vecs[4]  = mk(1'b0,1'b0,64'h0,     1'b0,1'b1,64'h8,   1'b0,64'h4,   64'h8);
    vecs[5]  = mk(1'b0,1'b0,64'h0,     1'b1,1'b1,64'hC,   1'b1,64'h8,   64'hC);
    vecs[6]  = mk(1'b1,1'b0,64'h0,     1'b1,1'b0,64'h10,  1'b1,64'h8,   64'hC);
    vecs[7]  = mk(1'b1,1'b0,64'h0,     1'b1,1'b0,64'h10,  1'b1,64'h8,   64'hC);
    vecs[8]  = mk(1'b0,1'b0,64'h0,     1'b1,1'b1,64'h10,  1'b1,64'hC,   64'h10);
    vecs[9]  = mk(1'b0,1'b1,64'h400,   1'b1,1'b1,64'h400, 1'b0,64'hC,   64'h10);
    vecs[10] = mk(1'b0,1'b0,64'h0,     1'b1,1'b1,64'h404, 1'b1,64'h400, 64'h404);
    vecs[11] = mk(1'b1,1'b0,64'h0,     1'b1,1'b0,64'h408, 1'b1,64'h400, 64'h404);
    vecs[12] = mk(1'b1,1'b1,64'h800,   1'b1,1'b1,64'h800, 1'b0,64'h400, 64'h404);
    vecs[13] = mk(1'b0,1'b0,64'h0,     1'b1,1'b1,64'h804, 1'b1,64'h800, 64'h804);
    vecs[14] = mk(1'b1,1'b0,64'h0,     1'b0,1'b1,64'h804, 1'b1,64'h800, 64'h804);
    vecs[15] = mk(1'b0,1'b0,64'h0,     1'b0,1'b1,64'h804, 1'b0,64'h800, 64'h804);

    reset = 1'b1; reset1 = 1'b1;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    rdy0 = 1'b0; rdy1 = 1'b0;

    // ---- reset state ----
    tick(); tick();
    check("rst_req",   {63'h0, bus0.imem_req}, 64'h0);
    check("rst_valid", {63'h0, valid0}, 64'h0);
    check("rst_instr", {32'h0, instruction0}, {32'h0, NOP});
    check("rst_pc",    pc_out0, 64'h0);
    check("rst_p4",    p4_out0, 64'h0);
    check("rst_addr",  bus0.imem_addr, 64'h0);
    reset = 1'b0;
    #1;
    check("post_rst_req", {63'h0, bus0.imem_req}, 64'h1);

    // ---- table-driven vectors: fetch stream, waits, stall/hold, branches ----
    for (int i = 0; i < 16; i++) begin
      stall         = vecs[i].stall;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      rdy0          = vecs[i].rdy;
      tick();
      stall = 1'b0; branch_taken = 1'b0; rdy0 = 1'b0;
      #1;
      check($sformatf("v%0d_req", i),   {63'h0, bus0.imem_req}, {63'h0, vecs[i].e_req});
      check($sformatf("v%0d_addr", i),  bus0.imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), {63'h0, valid0}, {63'h0, vecs[i].e_valid});
      check($sformatf("v%0d_pc", i),    pc_out0, vecs[i].e_pc);
      check($sformatf("v%0d_p4", i),    p4_out0, vecs[i].e_p4);
      check($sformatf("v%0d_instr", i), {32'h0, instruction0},
            {32'h0, vecs[i].e_valid ? word_of(vecs[i].e_pc) : NOP});
    end

    // ---- scoreboard phase: random memory readiness ----
    exp_addr = 64'h804;
    for (int c = 0; c < 40; c++) begin
      rdy0 = 1'($urandom_range(0, 1));
      #1;
      check("sb_req",  {63'h0, bus0.imem_req}, 64'h1);
      check("sb_addr", bus0.imem_addr, exp_addr);
      if (rdy0) begin
        exp_q.push_back({exp_addr, word_of(exp_addr)});
        exp_addr = exp_addr + 64'd4;
      end
      tick();
      if (valid0) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'h1, 64'h0);
        end else begin
          item = exp_q.pop_front();
          check("sb_instr", {32'h0, instruction0}, {32'h0, item[31:0]});
          check("sb_pc",    pc_out0, item[95:32]);
          check("sb_p4",    p4_out0, item[95:32] + 64'd4);
        end
      end else begin
        check("sb_bubble", {32'h0, instruction0}, {32'h0, NOP});
      end
    end
    rdy0 = 1'b0;
    check("sb_drained", 64'(exp_q.size()), 64'h0);

    // ---- top-of-memory reset PC, wrap, reset mid-wait ----
    check("w_rst_req", {63'h0, bus1.imem_req}, 64'h0);
    reset1 = 1'b0;
    #1;
    check("w_req",  {63'h0, bus1.imem_req}, 64'h1);
    check("w_addr", bus1.imem_addr, TOP_PC);
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    #1;
    check("w_valid", {63'h0, valid1}, 64'h1);
    check("w_pc",    pc_out1, TOP_PC);
    check("w_p4",    p4_out1, 64'h0);
    check("w_instr", {32'h0, instruction1}, {32'h0, word_of(TOP_PC)});
    check("w_next",  bus1.imem_addr, 64'h0);
    tick();  // waiting at address 0
    check("w_wait_valid", {63'h0, valid1}, 64'h0);
    reset1 = 1'b1;
    #1;
    check("w_rst_req_now", {63'h0, bus1.imem_req}, 64'h0);
    tick();
    reset1 = 1'b0;
    #1;
    check("w_re_addr",  bus1.imem_addr, TOP_PC);
    check("w_re_req",   {63'h0, bus1.imem_req}, 64'h1);
    check("w_re_valid", {63'h0, valid1}, 64'h0);
    check("w_re_pc",    pc_out1, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
